// File: rtl/ad9481_capture_ctrl_if.sv
// Purpose: bundles the capture controller's control, sample and buffer-write signals.
// Latency: none (wiring only).
// Backpressure: none; s_valid qualifies samples and the RAM write port always accepts.
// Ports:
//   start/abort/force_trig       capture control from software
//   trig_level/trig_edge         channel-A trigger threshold and polarity
//   s_valid/s_data               sample stream {chA, chB} from the ADC receiver
//   wr_en/wr_addr/wr_data        capture buffer RAM write port
//   trig_addr/frame_start        trigger sample address and oldest frame sample address
//   busy/done                    capture status
interface ad9481_capture_ctrl_if #(
    parameter int ADDR_W = 10
);
    logic              start;
    logic              abort;
    logic              force_trig;
    logic [7:0]        trig_level;
    logic              trig_edge;
    logic              s_valid;
    logic [15:0]       s_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       wr_data;
    logic [ADDR_W-1:0] trig_addr;
    logic [ADDR_W-1:0] frame_start;
    logic              busy;
    logic              done;

    // master: software/receiver side driving the controller
    modport master (
        output start, abort, force_trig, trig_level, trig_edge, s_valid, s_data,
        input  wr_en, wr_addr, wr_data, trig_addr, frame_start, busy, done
    );

    // slave: the capture controller itself
    modport slave (
        input  start, abort, force_trig, trig_level, trig_edge, s_valid, s_data,
        output wr_en, wr_addr, wr_data, trig_addr, frame_start, busy, done
    );
endinterface

// File: rtl/ad9481_capture_ctrl.sv
// Purpose: pre/post-trigger capture of the AD9481 sample stream into a circular RAM buffer.
// Latency: each valid sample appears on the RAM write port exactly one sys_clk later.
// Backpressure: none; every qualified sample in a busy state is written, abort drops the stream.
// Ports:
//   sys_clk   capture clock (ADC receiver domain)
//   sys_rst   asynchronous active-high reset
//   cap       slave side of ad9481_capture_ctrl_if (control, samples, RAM write, status)
module ad9481_capture_ctrl #(
    parameter int ADDR_W = 10,
    parameter int PRE    = 256
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    ad9481_capture_ctrl_if.slave   cap
);
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int POST_N = DEPTH - PRE;
    localparam int CW     = ADDR_W + 1;

    localparam logic [CW-1:0]     PRE_LAST  = CW'(PRE - 1);
    localparam logic [CW-1:0]     POST_LAST = CW'(POST_N - 1);
    localparam logic [ADDR_W-1:0] PRE_A     = ADDR_W'(PRE);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRE_FILL  = 3'd1,
        WAIT_TRIG = 3'd2,
        POST      = 3'd3,
        DONE      = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [7:0]        prev_q, prev_d;
    logic              force_q, force_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [15:0]       wr_data_q, wr_data_d;
    logic [ADDR_W-1:0] taddr_q, taddr_d;
    logic [ADDR_W-1:0] fstart_q, fstart_d;

    logic [7:0]        cha;
    logic              hit;

    assign cha = cap.s_data[15:8];

    // Edge detect against the previous valid chA sample, unsigned compare.
    always_comb begin
        hit = 1'b0;
        if (cap.trig_edge) begin
            hit = (cha <= cap.trig_level) && (prev_q > cap.trig_level);
        end else begin
            hit = (cha >= cap.trig_level) && (prev_q < cap.trig_level);
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        prev_d    = prev_q;
        force_d   = force_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        taddr_d   = taddr_q;
        fstart_d  = fstart_q;

        if (cap.abort) begin
            // Abort beats everything, including a sample arriving this cycle.
            state_d = IDLE;
            force_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (cap.start) begin
                        state_d = PRE_FILL;
                        ptr_d   = '0;
                        cnt_d   = '0;
                    end
                end

                PRE_FILL: begin
                    if (cap.s_valid) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = ptr_q;
                        wr_data_d = cap.s_data;
                        ptr_d     = ptr_q + 1'b1;
                        prev_d    = cha;
                        if (cnt_q == PRE_LAST) begin
                            state_d = WAIT_TRIG;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end

                WAIT_TRIG: begin
                    // A software request only arms the latch; it fires on a later sample.
                    if (cap.force_trig) begin
                        force_d = 1'b1;
                    end
                    if (cap.s_valid) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = ptr_q;
                        wr_data_d = cap.s_data;
                        ptr_d     = ptr_q + 1'b1;
                        prev_d    = cha;
                        if (force_q || hit) begin
                            taddr_d  = ptr_q;
                            fstart_d = ptr_q - PRE_A;
                            force_d  = 1'b0;
                            // The trigger sample itself is post-sample number one.
                            cnt_d    = CW'(1);
                            state_d  = (POST_N == 1) ? DONE : POST;
                        end
                    end
                end

                POST: begin
                    if (cap.s_valid) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = ptr_q;
                        wr_data_d = cap.s_data;
                        ptr_d     = ptr_q + 1'b1;
                        prev_d    = cha;
                        if (cnt_q == POST_LAST) begin
                            state_d = DONE;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            prev_q    <= '0;
            force_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            taddr_q   <= '0;
            fstart_q  <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            prev_q    <= prev_d;
            force_q   <= force_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            taddr_q   <= taddr_d;
            fstart_q  <= fstart_d;
        end
    end

    assign cap.wr_en       = wr_en_q;
    assign cap.wr_addr     = wr_addr_q;
    assign cap.wr_data     = wr_data_q;
    assign cap.trig_addr   = taddr_q;
    assign cap.frame_start = fstart_q;
    assign cap.busy        = (state_q == PRE_FILL) || (state_q == WAIT_TRIG) || (state_q == POST);
    assign cap.done        = (state_q == DONE);
endmodule
